regbank_reader: RTL and testbench
=================================

# regbank_reader

Read side of the 16 x 32-bit register bank. Accepts paired read requests (two register addresses per request) over a valid/ready handshake, samples the bank's parallel outputs with same-cycle write bypass, and returns both operands through a 2-entry response buffer. It sits between the bank's `q0..q15` outputs and the datapath/ALU operand inputs, mirroring the bank's one-hot write port.

## Interface
- `DATA_W`, 32, register width
- `NREG`, 16, number of registers
- `ADDR_W`, 4, register address width (log2 NREG)

- `clk`  in  1  sole clock, rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `regs_flat`  in  NREG*DATA_W  bank outputs; register i at bits [i*DATA_W +: DATA_W]
- `wr_en`  in  NREG  bank write enables, same vector driven into the bank
- `wr_data`  in  DATA_W  bank write data (`Din`)
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept a request
- `req_addr_a`, `req_addr_b`  in  ADDR_W each  operand register addresses
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer accepts response
- `rsp_data_a`, `rsp_data_b`  out  DATA_W each  operand values
- `rsp_bypass`  out  2  bit0/bit1: operand a/b was taken from `wr_data`
- `wr_multi`  out  1  sticky: `wr_en` had more than one bit set at some accepted request

## Operation
- Request accepted on a rising edge where `req_valid && req_ready`.
- Operand select at acceptance: if `wr_en[addr]` is 1, operand = `wr_data` and the matching `rsp_bypass` bit = 1; otherwise operand = `regs_flat` slice `addr`. Applied independently to a and b; `addr_a == addr_b` is legal and yields identical operands.
- Snapshot semantics: operands are fixed at acceptance; later bank writes do not alter buffered responses.
- Response buffer: 2-entry FIFO of {data_a, data_b, bypass}; head drives `rsp_*`. Response popped on an edge where `rsp_valid && rsp_ready`.
- Occupancy count 0..2. States: EMPTY (0), ONE (1), FULL (2).
  - EMPTY: push -> ONE.
  - ONE: push only -> FULL; pop only -> EMPTY; push+pop -> ONE.
  - FULL: pop -> ONE; push impossible (`req_ready` = 0).
- `wr_multi` is set when an accepted request sees `wr_en` with popcount > 1; cleared only by reset. Bypass still uses `wr_data` for every asserted bit.
- `rsp_*` data are don't-care while `rsp_valid` = 0.

## Timing
- All outputs registered; no combinational path from any input to any output.
- Reset (`reset_n` = 0 at an edge): count = 0, `rsp_valid` = 0, `req_ready` = 1, `rsp_data_a`/`rsp_data_b` = 0, `rsp_bypass` = 0, `wr_multi` = 0. Reset mid-operation discards all buffered responses; no response emerges after reset for pre-reset requests.
- Latency: request accepted at edge N appears on `rsp_*` after edge N when buffer was empty (1 cycle).
- Throughput: 1 request/cycle sustained when `rsp_ready` = 1 continuously.
- `req_ready` = (count after the edge < 2); computed from next count, so it deasserts in the cycle after the 2nd unpopped push and reasserts the cycle after a pop from FULL.
- Simultaneous push+pop in ONE: head replaced by new entry only if the popped entry was the head; order strictly FIFO.
- Data stability: `rsp_data_*`/`rsp_bypass` hold while `rsp_valid && !rsp_ready`.

## Structure
- Shared package `regbank_pkg`: `DATA_W`, `NREG`, `ADDR_W` constants, `reg_word_t` typedef, operand-pair response struct {data_a, data_b, bypass}. Bank write side imports the same package.
- One sub-module: `regbank_operand_sel` (combinational slice select + bypass for one address), instantiated twice. FIFO/count logic in top.

## Test plan
- Reset: hold `reset_n` = 0 two cycles -> `req_ready` = 1, `rsp_valid` = 0, `wr_multi` = 0, data = 0.
- Plain read: bank r3 = 0x0000_00A5, r7 = 0xDEAD_BEEF, request (3,7), `rsp_ready` = 1 -> next cycle `rsp_valid` = 1, a = 0xA5, b = 0xDEADBEEF, bypass = 00.
- Bypass: request (5,5) with `wr_en` = 0x0020, `wr_data` = 0x1234_5678, old r5 = 0 -> a = b = 0x12345678, bypass = 11; `wr_en` = 0x0021 on accept -> `wr_multi` = 1.
- Backpressure: `rsp_ready` = 0, issue 3 requests back-to-back -> first two accepted, `req_ready` = 0 on 3rd; release `rsp_ready` -> responses in issue order, third accepted next cycle.
- Snapshot: request r2 (= 0x11) with `rsp_ready` = 0, then write r2 = 0x22 -> response still 0x11.
- Mid-operation reset: FIFO FULL, assert reset -> `rsp_valid` = 0 next cycle, no stale responses after release.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared register-bank definitions, used by both the read side and the bank write side.
package regbank_pkg;
  localparam int DATA_W = 32;
  localparam int NREG   = 16;
  localparam int ADDR_W = 4;

  typedef logic [DATA_W-1:0] reg_word_t;

  typedef struct packed {
    reg_word_t  data_a;
    reg_word_t  data_b;
    logic [1:0] bypass;
  } rsp_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  // True when more than one write enable is asserted.
  function automatic logic multi_hot(input logic [NREG-1:0] v);
    return (v & (v - NREG'(1))) != '0;
  endfunction
endpackage

// File: rtl/regbank_operand_sel.sv
// Selects one register word from the flattened bank outputs, taking the
// in-flight write data instead when that register is being written this cycle.
module regbank_operand_sel
  import regbank_pkg::*;
(
  input  logic [NREG*DATA_W-1:0] regs_flat,
  input  logic [NREG-1:0]        wr_en,
  input  reg_word_t              wr_data,
  input  logic [ADDR_W-1:0]      addr,
  output reg_word_t              data,
  output logic                   bypass
);
  always_comb begin
    bypass = wr_en[addr];
    data   = bypass ? wr_data : regs_flat[addr*DATA_W +: DATA_W];
  end
endmodule

// File: rtl/regbank_reader.sv
// Read side of the register bank: paired operand reads with write bypass,
// returned through a two-entry response buffer with fully registered outputs.
module regbank_reader
  import regbank_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREG*DATA_W-1:0] regs_flat,
  input  logic [NREG-1:0]        wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_W-1:0]      req_addr_a,
  input  logic [ADDR_W-1:0]      req_addr_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_data_a,
  output logic [DATA_W-1:0]      rsp_data_b,
  output logic [1:0]             rsp_bypass,
  output logic                   wr_multi
);
  occ_t  state, state_nxt;
  rsp_t  head_p0, tail_p0, head_nxt, tail_nxt, new_ent;
  logic  vld_p0, rdy_p0, multi_p0;
  logic  push, pop;

  regbank_operand_sel u_sel_a (
    .regs_flat (regs_flat),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .addr      (req_addr_a),
    .data      (new_ent.data_a),
    .bypass    (new_ent.bypass[0])
  );

  regbank_operand_sel u_sel_b (
    .regs_flat (regs_flat),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .addr      (req_addr_b),
    .data      (new_ent.data_b),
    .bypass    (new_ent.bypass[1])
  );

  assign push = req_valid && rdy_p0;
  assign pop  = vld_p0 && rsp_ready;

  // Occupancy and entry movement; head always holds the oldest response.
  always_comb begin
    state_nxt = state;
    head_nxt  = head_p0;
    tail_nxt  = tail_p0;
    case (state)
      EMPTY: begin
        if (push) begin
          head_nxt  = new_ent;
          state_nxt = ONE;
        end
      end
      ONE: begin
        case ({push, pop})
          2'b10: begin
            tail_nxt  = new_ent;
            state_nxt = FULL;
          end
          2'b01:   state_nxt = EMPTY;
          2'b11:   head_nxt  = new_ent;
          default: ;
        endcase
      end
      FULL: begin
        if (pop) begin
          head_nxt  = tail_p0;
          state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Stage p0: buffer registers; handshake outputs derive from the next occupancy.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= EMPTY;
      head_p0  <= '0;
      tail_p0  <= '0;
      vld_p0   <= 1'b0;
      rdy_p0   <= 1'b1;
      multi_p0 <= 1'b0;
    end else begin
      state   <= state_nxt;
      head_p0 <= head_nxt;
      tail_p0 <= tail_nxt;
      vld_p0  <= (state_nxt != EMPTY);
      rdy_p0  <= (state_nxt != FULL);
      if (push && multi_hot(wr_en))
        multi_p0 <= 1'b1;
    end
  end

  assign req_ready  = rdy_p0;
  assign rsp_valid  = vld_p0;
  assign rsp_data_a = head_p0.data_a;
  assign rsp_data_b = head_p0.data_b;
  assign rsp_bypass = head_p0.bypass;
  assign wr_multi   = multi_p0;
endmodule

// File: tb/tb_regbank_reader.sv
// Bench for regbank_reader: directed scenarios then randomized traffic, checked
// against a queue-based model of the response buffer and an array model of the bank.
module tb_regbank_reader;
  import regbank_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset_n;
  logic [NREG*DATA_W-1:0] regs_flat;
  logic [NREG-1:0]        wr_en;
  logic [DATA_W-1:0]      wr_data;
  logic                   req_valid, req_ready;
  logic [ADDR_W-1:0]      req_addr_a, req_addr_b;
  logic                   rsp_valid, rsp_ready;
  logic [DATA_W-1:0]      rsp_data_a, rsp_data_b;
  logic [1:0]             rsp_bypass;
  logic                   wr_multi;

  logic [DATA_W-1:0] bank [NREG];
  always_comb
    for (int i = 0; i < NREG; i++) regs_flat[i*DATA_W +: DATA_W] = bank[i];

  regbank_reader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .regs_flat  (regs_flat),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr_a (req_addr_a),
    .req_addr_b (req_addr_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data_a (rsp_data_a),
    .rsp_data_b (rsp_data_b),
    .rsp_bypass (rsp_bypass),
    .wr_multi   (wr_multi)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  byp;
  } exp_t;

  exp_t q[$];
  logic exp_multi;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: predict from pre-edge inputs, advance the model, then compare.
  task automatic cycle();
    exp_t e;
    logic push, pop;
    logic [NREG-1:0] we;
    logic [DATA_W-1:0] wd;
    push  = reset_n && req_valid && (q.size() < 2);
    pop   = reset_n && rsp_ready && (q.size() > 0);
    e.a   = wr_en[req_addr_a] ? wr_data : bank[req_addr_a];
    e.b   = wr_en[req_addr_b] ? wr_data : bank[req_addr_b];
    e.byp = {wr_en[req_addr_b], wr_en[req_addr_a]};
    we    = wr_en;
    wd    = wr_data;
    @(posedge clk);
    #1;
    if (!reset_n) begin
      q.delete();
      exp_multi = 1'b0;
    end else begin
      if (pop) q.delete(0);
      if (push) q.push_back(e);
      if (push && $countones(we) > 1) exp_multi = 1'b1;
    end
    for (int i = 0; i < NREG; i++)
      if (we[i]) bank[i] = wd;
    check("req_ready", req_ready, q.size() < 2);
    check("rsp_valid", rsp_valid, q.size() > 0);
    check("wr_multi", wr_multi, exp_multi);
    if (q.size() > 0) begin
      check("data_a", rsp_data_a, q[0].a);
      check("data_b", rsp_data_b, q[0].b);
      check("bypass", rsp_bypass, q[0].byp);
    end
    if (!reset_n) begin
      check("rst_data_a", rsp_data_a, 0);
      check("rst_data_b", rsp_data_b, 0);
      check("rst_bypass", rsp_bypass, 0);
    end
  endtask

  task automatic bank_write(input int addr, input logic [31:0] val);
    req_valid = 1'b0;
    wr_en     = 16'(1) << addr;
    wr_data   = val;
    cycle();
    wr_en     = '0;
  endtask

  task automatic request(input int a, input int b);
    req_valid  = 1'b1;
    req_addr_a = ADDR_W'(a);
    req_addr_b = ADDR_W'(b);
    cycle();
    req_valid  = 1'b0;
  endtask

  initial begin
    int r;
    for (int i = 0; i < NREG; i++) bank[i] = '0;
    exp_multi  = 1'b0;
    reset_n    = 1'b0;
    wr_en      = '0;
    wr_data    = '0;
    req_valid  = 1'b0;
    req_addr_a = '0;
    req_addr_b = '0;
    rsp_ready  = 1'b1;

    // Reset held for two cycles
    repeat (2) cycle();
    check("reset_ready", req_ready, 1);
    check("reset_valid", rsp_valid, 0);
    reset_n = 1'b1;

    // Plain read
    bank_write(3, 32'h0000_00A5);
    bank_write(7, 32'hDEAD_BEEF);
    request(3, 7);
    check("plain_valid", rsp_valid, 1);
    check("plain_a", rsp_data_a, 32'h0000_00A5);
    check("plain_b", rsp_data_b, 32'hDEAD_BEEF);
    check("plain_byp", rsp_bypass, 2'b00);
    cycle();

    // Bypass, then multi-hot write enable
    wr_en = 16'h0020; wr_data = 32'h1234_5678;
    request(5, 5);
    wr_en = '0;
    check("byp_a", rsp_data_a, 32'h1234_5678);
    check("byp_b", rsp_data_b, 32'h1234_5678);
    check("byp_bits", rsp_bypass, 2'b11);
    check("multi_clear", wr_multi, 0);
    cycle();
    wr_en = 16'h0021; wr_data = 32'hCAFE_0001;
    request(5, 0);
    wr_en = '0;
    check("multi_set", wr_multi, 1);
    cycle();

    // Backpressure: third request stalls until a pop
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr_a = 4'd1; req_addr_b = 4'd2; cycle();
    req_addr_a = 4'd3; req_addr_b = 4'd4; cycle();
    check("bp_full_ready", req_ready, 0);
    req_addr_a = 4'd7; req_addr_b = 4'd3; cycle();
    check("bp_head_a", rsp_data_a, bank[1]);
    rsp_ready = 1'b1;
    cycle();
    check("bp_ready_back", req_ready, 1);
    check("bp_second_a", rsp_data_a, bank[3]);
    cycle();
    req_valid = 1'b0;
    check("bp_third_a", rsp_data_a, 32'hDEAD_BEEF);
    cycle();
    check("bp_drained", rsp_valid, 0);

    // Snapshot: later write must not disturb the buffered operand
    bank_write(2, 32'h11);
    rsp_ready = 1'b0;
    request(2, 2);
    bank_write(2, 32'h22);
    check("snap_a", rsp_data_a, 32'h11);
    rsp_ready = 1'b1;
    cycle();

    // Mid-operation reset with a full buffer
    rsp_ready = 1'b0;
    request(4, 6);
    request(6, 4);
    check("mid_full", req_ready, 0);
    reset_n = 1'b0;
    cycle();
    check("mid_rst_valid", rsp_valid, 0);
    reset_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (3) begin
      cycle();
      check("mid_no_stale", rsp_valid, 0);
    end

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      reset_n    = ($urandom_range(0, 299) != 0);
      req_valid  = $urandom_range(0, 1);
      rsp_ready  = ($urandom_range(0, 3) != 0);
      req_addr_a = ADDR_W'($urandom_range(0, NREG-1));
      req_addr_b = ADDR_W'($urandom_range(0, NREG-1));
      wr_data    = $urandom;
      r          = $urandom_range(0, 9);
      if (r < 5)      wr_en = '0;
      else if (r < 9) wr_en = 16'(1) << $urandom_range(0, NREG-1);
      else            wr_en = 16'($urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
